// File: rtl/tres_c.sv
// tres_c - registered 4-input Boolean function evaluator.
//
// Looks up x in a 16-entry truth table indexed by {a,b,c,d} and drives it
// from a flop. The default table flags the primes 2,3,5,7,11,13.
//
// Parameters:
//   TRUTH_TABLE  bit n is the value of x for {a,b,c,d} == n
//   RESET_X      value of x while rst_n is low and after reset release
//
// Ports:
//   clk    in   system clock, rising-edge active
//   rst_n  in   asynchronous, active-low reset
//   a      in   lookup index bit 3 (MSB)
//   b      in   lookup index bit 2
//   c      in   lookup index bit 1
//   d      in   lookup index bit 0 (LSB)
//   x      out  registered function output
//
// Build option:
//   TRES_C_DEGLITCH_EN  when defined, x only updates once the index has been
//                       seen on two consecutive edges (2-cycle latency,
//                       single-cycle input pulses are rejected).

module tres_c #(
  parameter logic [15:0] TRUTH_TABLE = 16'h28AC,
  parameter logic        RESET_X     = 1'b0
) (
  input  logic clk,
  input  logic rst_n,
  input  logic a,
  input  logic b,
  input  logic c,
  input  logic d,
  output logic x
);

  logic [3:0] idx;

  assign idx = {a, b, c, d};

`ifdef TRES_C_DEGLITCH_EN

  // The history is the live index plus the index captured on the previous
  // edge; the two agreeing means idx was equal on two consecutive edges.
  logic [3:0] idx_q;
  logic       stable;

  assign stable = (idx == idx_q);

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      idx_q <= '0;
      x     <= RESET_X;
    end else begin
      idx_q <= idx;
      if (stable) begin
        x <= TRUTH_TABLE[idx];
      end
    end
  end

`else

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      x <= RESET_X;
    end else begin
      x <= TRUTH_TABLE[idx];
    end
  end

`endif

endmodule

// File: tb/tb_tres_c.sv
// tb_tres_c - directed self-checking bench for tres_c.
//
// Two instances share the inputs: one with the default prime table, one
// with TRUTH_TABLE = 16'h8000 (AND of all four inputs). Inputs are driven
// and outputs sampled 1 time unit after the rising edge.
// Honours TRES_C_DEGLITCH_EN the same way the design does.

module tb_tres_c;

  logic clk;
  logic rst_n;
  logic a, b, c, d;
  logic x_prime;
  logic x_and;

  int unsigned n_checks;
  int unsigned n_fail;

  tres_c dut_prime (
    .clk   (clk),
    .rst_n (rst_n),
    .a     (a),
    .b     (b),
    .c     (c),
    .d     (d),
    .x     (x_prime)
  );

  tres_c #(
    .TRUTH_TABLE (16'h8000),
    .RESET_X     (1'b0)
  ) dut_and (
    .clk   (clk),
    .rst_n (rst_n),
    .a     (a),
    .b     (b),
    .c     (c),
    .d     (d),
    .x     (x_and)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  // Hand-derived prime flags for idx 0..15.
  logic exp_prime [16] = '{1'b0, 1'b0, 1'b1, 1'b1, 1'b0, 1'b1, 1'b0, 1'b1,
                           1'b0, 1'b0, 1'b0, 1'b1, 1'b0, 1'b1, 1'b0, 1'b0};

  task automatic check(input string tag, input logic obs, input logic exp);
    n_checks++;
    if (obs !== exp) begin
      n_fail++;
      $display("FAIL %s: got %b, expected %b (t=%0t)", tag, obs, exp, $time);
    end
  endtask

  task automatic drive(input logic [3:0] v);
    {a, b, c, d} = v;
  endtask

  task automatic tick();
    @(posedge clk);
    #1;
  endtask

  // Apply an index and wait long enough for it to reach x in either build.
  task automatic apply(input logic [3:0] v);
    drive(v);
    tick();
`ifdef TRES_C_DEGLITCH_EN
    tick();
`endif
  endtask

  initial begin
    #100000;
    $display("FAIL watchdog: simulation did not finish, expected finish before 100000");
    $fatal(1, "watchdog expired");
  end

  initial begin
    n_checks = 0;
    n_fail   = 0;

    // Reset held with all inputs high; the AND table would give 1 if the
    // flop were not held.
    rst_n = 1'b0;
    drive(4'hF);
    #1;
    check("rst_prime_immediate", x_prime, 1'b0);
    check("rst_and_immediate",   x_and,   1'b0);
    repeat (3) tick();
    check("rst_prime_clocked", x_prime, 1'b0);
    check("rst_and_clocked",   x_and,   1'b0);

    rst_n = 1'b1;
    tick();
    check("release_prime_idx15", x_prime, 1'b0);
`ifdef TRES_C_DEGLITCH_EN
    // History cleared to 0, so idx 15 is not yet stable on this edge.
    check("release_and_hold", x_and, 1'b0);
    tick();
    check("release_and_idx15", x_and, 1'b1);
`else
    check("release_and_idx15", x_and, 1'b1);
`endif

    // Exhaustive sweep.
    for (int i = 0; i < 16; i++) begin
      apply(4'(i));
      check($sformatf("sweep_prime_%0d", i), x_prime, exp_prime[i]);
      check($sformatf("sweep_and_%0d", i),   x_and,   (i == 15) ? 1'b1 : 1'b0);
    end

    // AND table boundary points.
    apply(4'd14);
    check("and_idx14", x_and, 1'b0);
    apply(4'd15);
    check("and_idx15", x_and, 1'b1);
    apply(4'd0);
    check("and_idx0",  x_and, 1'b0);

    // Async reset between edges while x is 1.
    apply(4'd7);
    check("pre_reset_idx7", x_prime, 1'b1);
    #1;
    rst_n = 1'b0;
    #1;
    check("async_reset_prime", x_prime, 1'b0);
    drive(4'd13);
    #1;
    rst_n = 1'b1;
    tick();
`ifdef TRES_C_DEGLITCH_EN
    check("post_reset_hold", x_prime, 1'b0);
    tick();
`endif
    check("post_reset_idx13", x_prime, 1'b1);

`ifdef TRES_C_DEGLITCH_EN
    // One-cycle pulse of idx 3 must not reach x.
    apply(4'd0);
    check("dg_idx0_held", x_prime, 1'b0);
    drive(4'd3);
    tick();
    check("dg_pulse_edge", x_prime, 1'b0);
    drive(4'd0);
    tick();
    check("dg_pulse_back0", x_prime, 1'b0);
    tick();
    check("dg_pulse_settled", x_prime, 1'b0);
    // idx 3 held two edges: x rises on the second.
    drive(4'd3);
    tick();
    check("dg_hold_edge1", x_prime, 1'b0);
    tick();
    check("dg_hold_edge2", x_prime, 1'b1);
`else
    // Back-to-back alternation 2,4,2,4.
    drive(4'd2); tick(); check("b2b_2a", x_prime, 1'b1);
    drive(4'd4); tick(); check("b2b_4a", x_prime, 1'b0);
    drive(4'd2); tick(); check("b2b_2b", x_prime, 1'b1);
    drive(4'd4); tick(); check("b2b_4b", x_prime, 1'b0);
`endif

    $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
    $finish;
  end

endmodule
